// File: rtl/sram_byte_arbiter.sv
// Multi-channel req/ack arbiter and timing controller for a 16-bit asynchronous SRAM
// with byte-lane steering. Pin strobes are registered from the next state so they never glitch.

module sram_byte_arbiter #(
   parameter int NCH       = 2,
   parameter int AW        = 19,
   parameter int WAIT      = 2,
   parameter int PRIO_MODE = 0
) (
   input  logic [0:0]        clk,
   input  logic [0:0]        rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    we,
   input  logic [NCH*AW-1:0] addr,
   input  logic [NCH*8-1:0]  wdata,
   output logic [NCH-1:0]    ack,
   output logic [7:0]        rdata,
   output logic [0:0]        busy,
   output logic [AW-2:0]     sram_addr,
   output logic [15:0]       sram_dq_o,
   input  logic [15:0]       sram_dq_i,
   output logic [0:0]        sram_dq_oe,
   output logic [0:0]        sram_ce_n,
   output logic [0:0]        sram_oe_n,
   output logic [0:0]        sram_we_n,
   output logic [0:0]        sram_ub_n,
   output logic [0:0]        sram_lb_n
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

   if (WAIT < 1) begin : g_bad_wait
      $error("sram_byte_arbiter: WAIT must be at least 1");
   end
   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("sram_byte_arbiter: NCH must be in 1..8");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic           we_q, we_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [7:0]     wdata_q, wdata_d;
   logic [7:0]     rdata_q, rdata_d;
   logic [NCH-1:0] ack_q, ack_d;
   logic           ce_n_q, ce_n_d;
   logic           oe_n_q, oe_n_d;
   logic           we_n_q, we_n_d;
   logic           ub_n_q, ub_n_d;
   logic           lb_n_q, lb_n_d;
   logic           dq_oe_q, dq_oe_d;

   logic [NCH-1:0] req_elig;
   logic           found;
   logic [IW-1:0]  pick;
   logic [IW-1:0]  idx;
   logic           grant;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      int c;
      c = int'(base) + k;
      if (c >= NCH) c = c - NCH;
      return IW'(c);
   endfunction

   // The channel acked in HOLD is excluded so a still-high req is not mistaken for a new one.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      req_elig = req;
      found    = 1'b0;
      pick     = '0;
      idx      = '0;
      if (state_q == S_HOLD) req_elig[gnt_q] = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         idx = (PRIO_MODE == 1) ? IW'(k) : rr_idx(ptr_q, k);
         if (!found && req_elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      grant   = 1'b0;

      case (state_q)
         S_IDLE:  grant = found;
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = CW'(WAIT - 1);
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               if (!we_q) rdata_d = addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            grant = found;
            if (!found) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (grant) begin
         state_d = S_SETUP;
         gnt_d   = pick;
         ptr_d   = (pick == IW'(NCH - 1)) ? '0 : pick + 1'b1;
         we_d    = we[pick];
         addr_d  = addr[pick*AW +: AW];
         wdata_d = wdata[pick*8 +: 8];
      end

      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      ub_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      ack_d   = '0;
      if (state_d != S_IDLE) begin
         ce_n_d  = 1'b0;
         ub_n_d  = ~addr_d[0];
         lb_n_d  = addr_d[0];
         oe_n_d  = we_d;
         dq_oe_d = we_d;
      end
      if (state_d == S_ACCESS) we_n_d = ~we_d;
      if (state_d == S_HOLD) ack_d[gnt_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
         dq_oe_q <= dq_oe_d;
      end
   end

   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign busy       = (state_q != S_IDLE);
   assign sram_addr  = addr_q[AW-1:1];
   assign sram_dq_o  = {wdata_q, wdata_q};
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_ub_n  = ub_n_q;
   assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_byte_arbiter.sv
// Bench for sram_byte_arbiter: three configurations (RR, fixed priority, NCH=3/WAIT=5)
// checked every cycle against a transfer-timeline model plus directed literal checks.

module tb_sram_byte_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req_0, req_1;
   logic [2:0]  req_2;
   logic [2:0]  we_v;
   logic [56:0] addr_v;
   logic [23:0] wdata_v;
   logic [15:0] dq_i;

   logic [1:0]  ack_0, ack_1;
   logic [2:0]  ack_2;
   logic [7:0]  rdata_m [3];
   logic [17:0] sa_m    [3];
   logic [15:0] dqo_m   [3];
   logic        busy_m  [3];
   logic        dqoe_m  [3];
   logic        ce_m    [3];
   logic        oe_m    [3];
   logic        wen_m   [3];
   logic        ub_m    [3];
   logic        lb_m    [3];

   int n_chk = 0;
   int n_err = 0;

   sram_byte_arbiter #(.NCH(2), .AW(19), .WAIT(2), .PRIO_MODE(0)) u_rr (
      .clk(clk), .rst(rst), .req(req_0), .we(we_v[1:0]), .addr(addr_v[37:0]),
      .wdata(wdata_v[15:0]), .ack(ack_0), .rdata(rdata_m[0]), .busy(busy_m[0]),
      .sram_addr(sa_m[0]), .sram_dq_o(dqo_m[0]), .sram_dq_i(dq_i), .sram_dq_oe(dqoe_m[0]),
      .sram_ce_n(ce_m[0]), .sram_oe_n(oe_m[0]), .sram_we_n(wen_m[0]),
      .sram_ub_n(ub_m[0]), .sram_lb_n(lb_m[0]));

   sram_byte_arbiter #(.NCH(2), .AW(19), .WAIT(2), .PRIO_MODE(1)) u_pr (
      .clk(clk), .rst(rst), .req(req_1), .we(we_v[1:0]), .addr(addr_v[37:0]),
      .wdata(wdata_v[15:0]), .ack(ack_1), .rdata(rdata_m[1]), .busy(busy_m[1]),
      .sram_addr(sa_m[1]), .sram_dq_o(dqo_m[1]), .sram_dq_i(dq_i), .sram_dq_oe(dqoe_m[1]),
      .sram_ce_n(ce_m[1]), .sram_oe_n(oe_m[1]), .sram_we_n(wen_m[1]),
      .sram_ub_n(ub_m[1]), .sram_lb_n(lb_m[1]));

   sram_byte_arbiter #(.NCH(3), .AW(19), .WAIT(5), .PRIO_MODE(0)) u_w (
      .clk(clk), .rst(rst), .req(req_2), .we(we_v), .addr(addr_v),
      .wdata(wdata_v), .ack(ack_2), .rdata(rdata_m[2]), .busy(busy_m[2]),
      .sram_addr(sa_m[2]), .sram_dq_o(dqo_m[2]), .sram_dq_i(dq_i), .sram_dq_oe(dqoe_m[2]),
      .sram_ce_n(ce_m[2]), .sram_oe_n(oe_m[2]), .sram_we_n(wen_m[2]),
      .sram_ub_n(ub_m[2]), .sram_lb_n(lb_m[2]));

   // Model: a transfer is a timeline of WAIT+2 cycles after grant (offset 0 = setup,
   // 1..WAIT = access, WAIT+1 = hold/ack); the pins follow directly from the offset.
   typedef struct {
      bit         act;
      int         ofs;
      int         gnt;
      bit         wr;
      logic [18:0] ad;
      logic [7:0]  wd;
      int         ptr;
      logic [7:0]  rd;
   } mdl_t;

   mdl_t m [3];
   int   m_nch  [3] = '{2, 2, 3};
   int   m_wt   [3] = '{2, 2, 5};
   bit   m_prio [3] = '{1'b0, 1'b1, 1'b0};

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   function automatic logic [2:0] req_of(input int i);
      case (i)
         0:       return {1'b0, req_0};
         1:       return {1'b0, req_1};
         default: return req_2;
      endcase
   endfunction

   function automatic logic [2:0] ack_of(input int i);
      case (i)
         0:       return {1'b0, ack_0};
         1:       return {1'b0, ack_1};
         default: return ack_2;
      endcase
   endfunction

   function automatic int pick(input int i, input logic [2:0] r);
      for (int k = 0; k < m_nch[i]; k++) begin
         int c;
         c = m_prio[i] ? k : (m[i].ptr + k) % m_nch[i];
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic m_start(input int i, input int g);
      m[i].act = 1'b1;
      m[i].ofs = 0;
      m[i].gnt = g;
      m[i].ptr = (g + 1) % m_nch[i];
      m[i].wr  = we_v[g];
      m[i].ad  = addr_v[g*19 +: 19];
      m[i].wd  = wdata_v[g*8 +: 8];
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int g;
         if (rst) begin
            m[i].act = 1'b0; m[i].ofs = 0; m[i].gnt = 0; m[i].wr = 1'b0;
            m[i].ad  = '0;   m[i].wd  = '0; m[i].ptr = 0; m[i].rd = '0;
         end else if (m[i].act && m[i].ofs == m_wt[i] + 1) begin
            g = pick(i, req_of(i) & ~(3'b001 << m[i].gnt));
            if (g >= 0) m_start(i, g);
            else m[i].act = 1'b0;
         end else if (m[i].act) begin
            if (m[i].ofs == m_wt[i] && !m[i].wr)
               m[i].rd = m[i].ad[0] ? dq_i[15:8] : dq_i[7:0];
            m[i].ofs++;
         end else begin
            g = pick(i, req_of(i));
            if (g >= 0) m_start(i, g);
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         logic [6:0] e_pins, g_pins;
         logic [2:0] e_ack;
         bit a, w;
         a = m[i].act;
         w = m[i].wr;
         e_pins = {a, !a, !(a && !w), !(a && w && m[i].ofs >= 1 && m[i].ofs <= m_wt[i]),
                   a ? ~m[i].ad[0] : 1'b1, a ? m[i].ad[0] : 1'b1, a && w};
         g_pins = {busy_m[i], ce_m[i], oe_m[i], wen_m[i], ub_m[i], lb_m[i], dqoe_m[i]};
         e_ack  = (a && m[i].ofs == m_wt[i] + 1) ? (3'b001 << m[i].gnt) : 3'b000;
         check($sformatf("cyc i%0d busy/ce/oe/we/ub/lb/oe_dq", i), g_pins, e_pins);
         check($sformatf("cyc i%0d ack", i), ack_of(i), e_ack);
         check($sformatf("cyc i%0d rdata", i), rdata_m[i], m[i].rd);
         check($sformatf("cyc i%0d sram_addr", i), sa_m[i], m[i].ad[18:1]);
         check($sformatf("cyc i%0d dq_o", i), dqo_m[i], {m[i].wd, m[i].wd});
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      compare_all();
   end

   task automatic set_ch(input int ch, input bit w, input logic [18:0] a, input logic [7:0] d);
      we_v[ch]            = w;
      addr_v[ch*19 +: 19] = a;
      wdata_v[ch*8 +: 8]  = d;
   endtask

   task automatic set_req(input int i, input int ch, input logic v);
      case (i)
         0:       req_0[ch] = v;
         1:       req_1[ch] = v;
         default: req_2[ch] = v;
      endcase
   endtask

   // One isolated transfer from IDLE; read data is presented only in the last access cycle.
   task automatic run_xfer(input int i, input int ch, input bit w, input logic [18:0] a,
                           input logic [7:0] d, input logic [15:0] dq,
                           output logic [2:0] ack_seen, output logic [7:0] rd_seen);
      set_ch(ch, w, a, d);
      dq_i = '0;
      set_req(i, ch, 1'b1);
      repeat (m_wt[i] + 1) @(negedge clk);
      dq_i = dq;
      @(negedge clk);
      ack_seen = ack_of(i);
      rd_seen  = rdata_m[i];
      set_req(i, ch, 1'b0);
      dq_i = '0;
      @(negedge clk);
   endtask

   task automatic wait_ack(input int i, input int max, output logic [2:0] a, output int n);
      a = '0;
      n = 0;
      while (n < max) begin
         @(negedge clk);
         n++;
         a = ack_of(i);
         if (a != 3'b000) break;
      end
   endtask

   initial begin
      logic [2:0] a;
      logic [7:0] r;
      int         n;

      rst = 1'b1; req_0 = '0; req_1 = '0; req_2 = '0;
      we_v = '0; addr_v = '0; wdata_v = '0; dq_i = '0;
      repeat (3) @(negedge clk);
      check("reset ce_n", ce_m[0], 1'b1);
      check("reset dq_oe", dqoe_m[0], 1'b0);
      check("reset busy", busy_m[2], 1'b0);
      rst = 1'b0;

      // Write 8'hA5 to byte 1: upper lane, duplicated data, ack WAIT+2 cycles after req.
      set_ch(0, 1'b1, 19'h00001, 8'hA5);
      req_0[0] = 1'b1;
      @(negedge clk);
      check("t1 setup ce_n", ce_m[0], 1'b0);
      check("t1 setup we_n", wen_m[0], 1'b1);
      check("t1 setup dq_oe", dqoe_m[0], 1'b1);
      check("t1 sram_addr", sa_m[0], 18'h0);
      check("t1 ub_n/lb_n", {ub_m[0], lb_m[0]}, 2'b01);
      check("t1 dq_o", dqo_m[0], 16'hA5A5);
      @(negedge clk);
      check("t1 access1 we_n", wen_m[0], 1'b0);
      @(negedge clk);
      check("t1 access2 we_n", wen_m[0], 1'b0);
      @(negedge clk);
      check("t1 ack", ack_0, 2'b01);
      check("t1 hold we_n", wen_m[0], 1'b1);
      req_0[0] = 1'b0;
      @(negedge clk);
      check("t1 idle ce_n", ce_m[0], 1'b1);
      check("t1 idle busy", busy_m[0], 1'b0);

      // Reads pick the byte lane from a0; a later write leaves rdata untouched.
      run_xfer(0, 0, 1'b0, 19'h00001, 8'h00, 16'hA53C, a, r);
      check("t2 read a0=1 ack", a, 3'b001);
      check("t2 read a0=1 rdata", r, 8'hA5);
      run_xfer(0, 0, 1'b0, 19'h00000, 8'h00, 16'hA53C, a, r);
      check("t2 read a0=0 rdata", r, 8'h3C);
      run_xfer(0, 0, 1'b1, 19'h00002, 8'h77, 16'h0000, a, r);
      check("t2 rdata kept over write", r, 8'h3C);
      run_xfer(0, 1, 1'b1, 19'h7FFFE, 8'h5A, 16'h0000, a, r);
      check("t2 ch1 ack", a, 3'b010);

      // Round robin with both channels held: 0,1,0,1 back to back.
      req_0 = 2'b11;
      for (int j = 0; j < 4; j++) begin
         wait_ack(0, 12, a, n);
         check($sformatf("t3 grant %0d", j), a, (j % 2 == 0) ? 3'b001 : 3'b010);
         check($sformatf("t3 spacing %0d", j), n, 4);
      end
      req_0 = 2'b00;
      @(negedge clk);

      // Fixed priority: ch0 wins a simultaneous request even though the pointer favours ch1.
      run_xfer(1, 0, 1'b1, 19'h00100, 8'h11, 16'h0000, a, r);
      check("t4 solo ch0 ack", a, 3'b001);
      req_1 = 2'b11;
      wait_ack(1, 8, a, n);
      check("t4 prio first grant", a, 3'b001);
      check("t4 prio latency", n, 4);
      req_1[0] = 1'b0;
      wait_ack(1, 8, a, n);
      check("t4 ch1 after ch0 drops", a, 3'b010);
      check("t4 ch1 back to back", n, 4);
      req_1 = 2'b00;
      @(negedge clk);

      // Reset in the middle of a write aborts immediately with no ack.
      set_ch(0, 1'b1, 19'h00010, 8'hC3);
      req_0[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5 access we_n", wen_m[0], 1'b0);
      rst = 1'b1;
      req_0[0] = 1'b0;
      @(negedge clk);
      check("t5 abort we_n", wen_m[0], 1'b1);
      check("t5 abort ce_n", ce_m[0], 1'b1);
      check("t5 abort dq_oe", dqoe_m[0], 1'b0);
      check("t5 abort ack", ack_0, 2'b00);
      check("t5 reset rdata", rdata_m[0], 8'h00);
      check("t5 reset sram_addr", sa_m[0], 18'h0);
      rst = 1'b0;
      @(negedge clk);
      check("t5 no late ack", ack_0, 2'b00);
      run_xfer(0, 0, 1'b1, 19'h00010, 8'hC3, 16'h0000, a, r);
      check("t5 post-reset write ack", a, 3'b001);
      run_xfer(0, 0, 1'b0, 19'h00010, 8'h00, 16'h12C3, a, r);
      check("t5 post-reset read", r, 8'hC3);

      // WAIT=5, NCH=3: ch2 drops req mid-access yet is acked at +7; pointer then wraps to 0.
      run_xfer(2, 0, 1'b1, 19'h00020, 8'h44, 16'h0000, a, r);
      check("t6 ch0 ack", a, 3'b001);
      set_ch(2, 1'b0, 19'h00003, 8'h00);
      dq_i = 16'h1111;
      req_2[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req_2[2] = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      dq_i = 16'hBEEF;
      check("t6 no early ack", ack_2, 3'b000);
      @(negedge clk);
      check("t6 ack ch2 at +7", ack_2, 3'b100);
      check("t6 rdata last-access capture", rdata_m[2], 8'hBE);
      dq_i = 16'h0000;
      @(negedge clk);
      check("t6 idle after drop", busy_m[2], 1'b0);
      req_2 = 3'b011;
      wait_ack(2, 10, a, n);
      check("t6 pointer at 0", a, 3'b001);
      check("t6 latency", n, 7);
      wait_ack(2, 10, a, n);
      check("t6 next ch1", a, 3'b010);
      check("t6 b2b spacing", n, 7);
      req_2 = 3'b111;
      wait_ack(2, 10, a, n);
      check("t6 all-req ch2", a, 3'b100);
      wait_ack(2, 10, a, n);
      check("t6 wrap to ch0", a, 3'b001);
      wait_ack(2, 10, a, n);
      check("t6 then ch1", a, 3'b010);
      req_2 = 3'b000;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
      $fatal(1);
   end

endmodule
